fma_unpack_pipe: RTL and testbench

FMA_UNPACK_PIPE -- requirements
Module: fma_unpack_pipe

---
 rtl/fma_pkg.sv | 34 +++
 rtl/fma_lzc.sv | 22 ++
 rtl/fma_unpack_pipe.sv | 140 ++++++++++++++
 tb/tb_fma_unpack_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared constants for the FMA operand unpack path: default operand format, class flag layout
// and the standard IEEE-754 format presets.
package fma_pkg;

   typedef enum logic [1:0] {FmtHalf, FmtSingle, FmtDouble} fmtT;

   localparam int unsigned DefaultWidth    = 32;
   localparam int unsigned DefaultExpWidth = 8;

   // Bit positions within the per-operand class vector {snan,qnan,inf,zero,subnormal}.
   localparam int unsigned ClsSub   = 0;
   localparam int unsigned ClsZero  = 1;
   localparam int unsigned ClsInf   = 2;
   localparam int unsigned ClsQnan  = 3;
   localparam int unsigned ClsSnan  = 4;
   localparam int unsigned ClsWidth = 5;

   function automatic int unsigned fmtWidth(fmtT fmt);
      case (fmt)
         FmtHalf:   return 16;
         FmtDouble: return 64;
         default:   return 32;
      endcase
   endfunction

   function automatic int unsigned fmtExpWidth(fmtT fmt);
      case (fmt)
         FmtHalf:   return 5;
         FmtDouble: return 11;
         default:   return 8;
      endcase
   endfunction

endpackage

// File: rtl/fma_lzc.sv
// Leading-zero counter: number of zero bits above the most significant set bit of value
// (WIDTH when value is zero).
module fma_lzc #(
   parameter int unsigned WIDTH = 24
) (
   input  logic [WIDTH-1:0]           value,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   // Scanning upward lets the highest set bit have the last word.
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) begin
            count = CW'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fma_unpack_pipe.sv
// Two-stage unpack of NUM_OPS IEEE-754 operands into sign, exponent, explicit-bit significand
// and class. Define FMA_SUBNORM_NORM_EN to normalise subnormals; otherwise they flush to zero.
module fma_unpack_pipe
   import fma_pkg::*;
#(
   parameter  int unsigned WIDTH     = DefaultWidth,
   parameter  int unsigned EXP_WIDTH = DefaultExpWidth,
   parameter  int unsigned NUM_OPS   = 3,
   localparam int unsigned SIG_WIDTH = WIDTH - EXP_WIDTH - 1,
   localparam int unsigned XW        = EXP_WIDTH + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_OPS*WIDTH-1:0]         in_ops,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NUM_OPS-1:0]               out_sign,
   output logic [NUM_OPS*XW-1:0]            out_exp,
   output logic [NUM_OPS*(SIG_WIDTH+1)-1:0] out_sig,
   output logic [NUM_OPS*ClsWidth-1:0]      out_class
);

   localparam int unsigned CW = $clog2(SIG_WIDTH + 2);

   typedef logic [ClsWidth-1:0] clsT;

   logic                              s1Valid, s2Valid, s1Advance;
   logic [NUM_OPS-1:0]                rawSign, s1Sign, s2Sign;
   logic [NUM_OPS-1:0][XW-1:0]        rawExp, s1Exp, s2Exp, normExp;
   logic [NUM_OPS-1:0][SIG_WIDTH-1:0] rawFrac, s1Frac;
   logic [NUM_OPS-1:0][SIG_WIDTH:0]   s2Sig, normSig;
   clsT  [NUM_OPS-1:0]                rawClass, s1Class, s2Class, normClass;
   logic [NUM_OPS-1:0][CW-1:0]        lzCnt;

   assign s1Advance = !s2Valid || out_ready;
   assign in_ready  = !s1Valid || s1Advance;

   for (genvar g = 0; g < NUM_OPS; g++) begin : genOp
      logic [EXP_WIDTH-1:0] expField;
      logic                 expZero, expOnes, fracZero, fracMsb;
      clsT                  cls;

      assign expField   = in_ops[g*WIDTH+SIG_WIDTH +: EXP_WIDTH];
      assign rawFrac[g] = in_ops[g*WIDTH +: SIG_WIDTH];
      assign rawSign[g] = in_ops[g*WIDTH+WIDTH-1];
      assign rawExp[g]  = {1'b0, expField};

      assign expZero  = (expField == '0);
      assign expOnes  = &expField;
      assign fracZero = (rawFrac[g] == '0);
      assign fracMsb  = rawFrac[g][SIG_WIDTH-1];

      always_comb begin
         cls          = '0;
         cls[ClsZero] = expZero & fracZero;
         cls[ClsSub]  = expZero & !fracZero;
         cls[ClsInf]  = expOnes & fracZero;
         cls[ClsQnan] = expOnes & fracMsb;
         cls[ClsSnan] = expOnes & !fracMsb & !fracZero;
      end
      assign rawClass[g] = cls;

      fma_lzc #(
         .WIDTH(SIG_WIDTH + 1)
      ) uLzc (
         .value({1'b0, s1Frac[g]}),
         .count(lzCnt[g])
      );
   end

   // Normal, inf and NaN keep {1,frac} and their biased exponent; only zero/subnormal differ.
   always_comb begin
      for (int i = 0; i < NUM_OPS; i++) begin
         normSig[i]   = {1'b1, s1Frac[i]};
         normExp[i]   = s1Exp[i];
         normClass[i] = s1Class[i];
         if (s1Class[i][ClsZero]) begin
            normSig[i] = '0;
            normExp[i] = '0;
         end else if (s1Class[i][ClsSub]) begin
`ifdef FMA_SUBNORM_NORM_EN
            normSig[i] = {1'b0, s1Frac[i]} << lzCnt[i];
            normExp[i] = XW'(1) - XW'(lzCnt[i]);
`else
            normSig[i]            = '0;
            normExp[i]            = '0;
            normClass[i][ClsZero] = 1'b1;
`endif
         end
      end
   end

`ifndef FMA_SUBNORM_NORM_EN
   logic unusedLz;
   assign unusedLz = ^lzCnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid <= 1'b0;
         s2Valid <= 1'b0;
         s1Sign  <= '0;
         s1Exp   <= '0;
         s1Frac  <= '0;
         s1Class <= '0;
         s2Sign  <= '0;
         s2Exp   <= '0;
         s2Sig   <= '0;
         s2Class <= '0;
      end else begin
         if (in_ready) begin
            s1Valid <= in_valid;
         end
         if (in_valid && in_ready) begin
            s1Sign  <= rawSign;
            s1Exp   <= rawExp;
            s1Frac  <= rawFrac;
            s1Class <= rawClass;
         end
         if (s1Advance) begin
            s2Valid <= s1Valid;
         end
         if (s1Advance && s1Valid) begin
            s2Sign  <= s1Sign;
            s2Exp   <= normExp;
            s2Sig   <= normSig;
            s2Class <= normClass;
         end
      end
   end

   assign out_valid = s2Valid;
   assign out_sign  = s2Sign;
   assign out_exp   = s2Exp;
   assign out_sig   = s2Sig;
   assign out_class = s2Class;

endmodule

// File: tb/tb_fma_unpack_pipe.sv
// Bench for fma_unpack_pipe: directed vector table, handshake/reset sequences, a randomized
// stream scored against a value-level reference model, and a half-precision instance.
`timescale 1ns/1ps
module tb_fma_unpack_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid, inReady, outValid, outReady;
   logic [95:0] inOps;
   logic [2:0]  outSign;
   logic [26:0] outExp;
   logic [71:0] outSig;
   logic [14:0] outClass;

   logic        hValid, hReady, hOutValid;
   logic [31:0] hOps;
   logic [1:0]  hSign;
   logic [11:0] hExp;
   logic [21:0] hSig;
   logic [9:0]  hClass;

   int          vectors = 0;
   int          miscompares = 0;
   int          delivered = 0;
   logic [95:0] pending[$];

   typedef struct {
      bit               sign;
      int               exp;
      longint unsigned  sig;
      bit [4:0]         cls;
   } unpackT;

   typedef struct {
      logic [31:0] op;
      logic        sign;
      logic [8:0]  exp;
      logic [23:0] sig;
      logic [4:0]  cls;
   } vecT;

   always #5 clk = ~clk;

   fma_unpack_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (inValid),
      .in_ready (inReady),
      .in_ops   (inOps),
      .out_valid(outValid),
      .out_ready(outReady),
      .out_sign (outSign),
      .out_exp  (outExp),
      .out_sig  (outSig),
      .out_class(outClass)
   );

   fma_unpack_pipe #(
      .WIDTH    (16),
      .EXP_WIDTH(5),
      .NUM_OPS  (2)
   ) dutHalf (
      .clk      (clk),
      .rst      (rst),
      .in_valid (hValid),
      .in_ready (hReady),
      .in_ops   (hOps),
      .out_valid(hOutValid),
      .out_ready(1'b1),
      .out_sign (hSign),
      .out_exp  (hExp),
      .out_sig  (hSig),
      .out_class(hClass)
   );

   // Value-level reference: decode fields arithmetically, normalise by repeated doubling.
   function automatic unpackT refUnpack(input logic [63:0] op, input int ew, input int sw);
      unpackT          r;
      longint unsigned frac;
      int              e;
      int              eMax;
      frac   = op & ((64'd1 << sw) - 1);
      e      = int'((op >> sw) & ((64'd1 << ew) - 1));
      eMax   = (1 << ew) - 1;
      r.sign = op[sw + ew];
      r.cls  = 5'b00000;
      r.exp  = e;
      r.sig  = frac + (64'd1 << sw);
      if (e == 0 && frac == 0) begin
         r.cls = 5'b00010;
         r.exp = 0;
         r.sig = 0;
      end else if (e == 0) begin
`ifdef FMA_SUBNORM_NORM_EN
         r.cls = 5'b00001;
         r.exp = 1;
         r.sig = frac;
         while (r.sig < (64'd1 << sw)) begin
            r.sig = r.sig * 2;
            r.exp = r.exp - 1;
         end
`else
         r.cls = 5'b00011;
         r.exp = 0;
         r.sig = 0;
`endif
      end else if (e == eMax) begin
         if (frac == 0) r.cls = 5'b00100;
         else if (((frac >> (sw - 1)) & 1) == 1) r.cls = 5'b01000;
         else r.cls = 5'b10000;
      end
      return r;
   endfunction

   function automatic logic [63:0] randOp(input int ew, input int sw);
      logic [63:0] e;
      logic [63:0] f;
      case ($urandom_range(0, 4))
         0:       e = 0;
         1:       e = (64'd1 << ew) - 1;
         default: e = 64'($urandom_range(1, (1 << ew) - 2));
      endcase
      case ($urandom_range(0, 3))
         0:       f = 0;
         1:       f = 64'd1 << $urandom_range(0, sw - 1);
         default: f = {$urandom, $urandom} & ((64'd1 << sw) - 1);
      endcase
      return (64'($urandom_range(0, 1)) << (ew + sw)) | (e << sw) | f;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic checkOp(input string tag, input int ew, input int sw, input logic [63:0] op,
                          input logic s, input logic [63:0] e, input logic [63:0] sig,
                          input logic [4:0] cls);
      unpackT r;
      r = refUnpack(op, ew, sw);
      check({tag, ".sign"}, 128'(s), 128'(r.sign));
      check({tag, ".exp"}, 128'(e), 128'(longint'(r.exp) & ((64'd1 << (ew + 1)) - 1)));
      check({tag, ".sig"}, 128'(sig), 128'(r.sig));
      check({tag, ".cls"}, 128'(cls), 128'(r.cls));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: transfers are decided at the negedge, where everything is stable.
   initial begin : monitor
      logic         stallPrev;
      logic [116:0] held;
      logic [95:0]  head;
      stallPrev = 1'b0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pending.delete();
            stallPrev = 1'b0;
         end else begin
            if (stallPrev) begin
               check("hold.valid", 128'(outValid), 128'(1));
               check("hold.data", 128'({outSign, outExp, outSig, outClass}), 128'(held));
            end
            check("inReady", 128'(inReady), 128'(!(pending.size() == 2 && !outReady)));
            if (pending.size() == 0) begin
               check("outValid.idle", 128'(outValid), 128'(0));
            end else if (outValid && outReady) begin
               head = pending.pop_front();
               delivered++;
               for (int i = 0; i < 3; i++) begin
                  checkOp($sformatf("sb.op%0d", i), 8, 23, 64'(head[i*32 +: 32]), outSign[i],
                          64'(outExp[i*9 +: 9]), 64'(outSig[i*24 +: 24]), outClass[i*5 +: 5]);
               end
            end
            if (inValid && inReady) pending.push_back(inOps);
            stallPrev = outValid && !outReady;
            held      = {outSign, outExp, outSig, outClass};
         end
      end
   end

   initial begin
      vecT         tbl[12];
      logic [95:0] b[4];
      logic [31:0] op0, op1;
      logic [31:0] hList[8];
      int          idx, d0;
      logic        sawFull;

      tbl[0]  = '{32'h3F800000, 1'b0, 9'h07F, 24'h800000, 5'b00000};
      tbl[1]  = '{32'h40000000, 1'b0, 9'h080, 24'h800000, 5'b00000};
      tbl[2]  = '{32'h00000000, 1'b0, 9'h000, 24'h000000, 5'b00010};
      tbl[3]  = '{32'h80000000, 1'b1, 9'h000, 24'h000000, 5'b00010};
      tbl[4]  = '{32'h7F800000, 1'b0, 9'h0FF, 24'h800000, 5'b00100};
      tbl[5]  = '{32'h7FC00000, 1'b0, 9'h0FF, 24'hC00000, 5'b01000};
      tbl[6]  = '{32'h7F800001, 1'b0, 9'h0FF, 24'h800001, 5'b10000};
      tbl[7]  = '{32'h7F7FFFFF, 1'b0, 9'h0FE, 24'hFFFFFF, 5'b00000};
      tbl[8]  = '{32'h00800000, 1'b0, 9'h001, 24'h800000, 5'b00000};
`ifdef FMA_SUBNORM_NORM_EN
      tbl[9]  = '{32'h00000001, 1'b0, 9'h1EA, 24'h800000, 5'b00001};
      tbl[10] = '{32'h807FFFFF, 1'b1, 9'h000, 24'hFFFFFE, 5'b00001};
      tbl[11] = '{32'h00400000, 1'b0, 9'h000, 24'h800000, 5'b00001};
`else
      tbl[9]  = '{32'h00000001, 1'b0, 9'h000, 24'h000000, 5'b00011};
      tbl[10] = '{32'h807FFFFF, 1'b1, 9'h000, 24'h000000, 5'b00011};
      tbl[11] = '{32'h00400000, 1'b0, 9'h000, 24'h000000, 5'b00011};
`endif
      hList = '{32'h0001, 32'h3C00, 32'h7C00, 32'h7E00, 32'h7C01, 32'h8000, 32'h03FF, 32'h0200};

      rst      = 1'b1;
      inValid  = 1'b0;
      inOps    = '0;
      outReady = 1'b0;
      hValid   = 1'b0;
      hOps     = '0;
      repeat (3) tick();
      check("rst.outValid", 128'(outValid), 128'(0));
      check("rst.outSign", 128'(outSign), 128'(0));
      check("rst.outExp", 128'(outExp), 128'(0));
      check("rst.outSig", 128'(outSig), 128'(0));
      check("rst.outClass", 128'(outClass), 128'(0));
      rst = 1'b0;
      tick();
      check("rst.inReady", 128'(inReady), 128'(1));

      // Single bundle: result visible exactly two edges after acceptance.
      outReady = 1'b1;
      inValid  = 1'b1;
      inOps    = {32'h00000000, 32'h40000000, 32'h3F800000};
      tick();
      inValid = 1'b0;
      check("lat1.outValid", 128'(outValid), 128'(0));
      tick();
      check("lat2.outValid", 128'(outValid), 128'(1));
      check("lat.sigA", 128'(outSig[23:0]), 128'(24'h800000));
      check("lat.sigB", 128'(outSig[47:24]), 128'(24'h800000));
      check("lat.expA", 128'(outExp[8:0]), 128'(9'h07F));
      check("lat.expB", 128'(outExp[17:9]), 128'(9'h080));
      check("lat.clsC", 128'(outClass[14:10]), 128'(5'b00010));
      check("lat.sigC", 128'(outSig[71:48]), 128'(0));
      tick();

      for (int k = 0; k < 12; k++) begin
         inValid = 1'b1;
         inOps   = {3{tbl[k].op}};
         tick();
         inValid = 1'b0;
         tick();
         check($sformatf("tbl%0d.valid", k), 128'(outValid), 128'(1));
         for (int i = 0; i < 3; i++) begin
            check($sformatf("tbl%0d.sign", k), 128'(outSign[i]), 128'(tbl[k].sign));
            check($sformatf("tbl%0d.exp", k), 128'(outExp[i*9 +: 9]), 128'(tbl[k].exp));
            check($sformatf("tbl%0d.sig", k), 128'(outSig[i*24 +: 24]), 128'(tbl[k].sig));
            check($sformatf("tbl%0d.cls", k), 128'(outClass[i*5 +: 5]), 128'(tbl[k].cls));
         end
      end
      tick();

      // Four back-to-back bundles with the sink stalled in cycles 3..5.
      for (int j = 0; j < 4; j++) begin
         b[j] = {32'(randOp(8, 23)), 32'(randOp(8, 23)), 32'(randOp(8, 23))};
      end
      idx     = 0;
      d0      = delivered;
      sawFull = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         outReady = !(c >= 3 && c <= 5);
         inValid  = (idx < 4);
         inOps    = b[(idx < 4) ? idx : 0];
         @(negedge clk);
         if (!inReady) sawFull = 1'b1;
         if (inValid && inReady) idx++;
         tick();
      end
      inValid = 1'b0;
      check("bp.accepted", 128'(idx), 128'(4));
      check("bp.delivered", 128'(delivered - d0), 128'(4));
      check("bp.inReadyLow", 128'(sawFull), 128'(1));

      // Reset with both stages occupied: nothing stale may come out afterwards.
      outReady = 1'b0;
      for (int j = 0; j < 2; j++) begin
         inValid = 1'b1;
         inOps   = {32'(randOp(8, 23)), 32'(randOp(8, 23)), 32'(randOp(8, 23))};
         tick();
      end
      inValid = 1'b0;
      check("flush.full", 128'(outValid), 128'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("flush.outValid", 128'(outValid), 128'(0));
      check("flush.inReady", 128'(inReady), 128'(1));
      outReady = 1'b1;
      repeat (4) begin
         tick();
         check("flush.quiet", 128'(outValid), 128'(0));
      end

      for (int c = 0; c < 400; c++) begin
         inValid  = ($urandom_range(0, 9) < 7);
         inOps    = {32'(randOp(8, 23)), 32'(randOp(8, 23)), 32'(randOp(8, 23))};
         outReady = ($urandom_range(0, 9) < 6);
         tick();
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      repeat (6) tick();
      check("drain.empty", 128'(pending.size()), 128'(0));

      // Half precision instance, smallest subnormal first.
      hValid = 1'b1;
      hOps   = {16'h0000, 16'h0001};
      tick();
      hValid = 1'b0;
      tick();
      check("half.valid", 128'(hOutValid), 128'(1));
`ifdef FMA_SUBNORM_NORM_EN
      check("half.sig", 128'(hSig[10:0]), 128'(11'h400));
      check("half.exp", 128'(hExp[5:0]), 128'(6'h37));
      check("half.cls", 128'(hClass[4:0]), 128'(5'b00001));
`else
      check("half.sig", 128'(hSig[10:0]), 128'(11'h000));
      check("half.exp", 128'(hExp[5:0]), 128'(6'h00));
      check("half.cls", 128'(hClass[4:0]), 128'(5'b00011));
`endif
      for (int k = 0; k < 28; k++) begin
         op0    = (k < 8) ? hList[k] : 32'(randOp(5, 10));
         op1    = 32'(randOp(5, 10));
         hValid = 1'b1;
         hOps   = {op1[15:0], op0[15:0]};
         check("half.inReady", 128'(hReady), 128'(1));
         tick();
         hValid = 1'b0;
         tick();
         check("half.outValid", 128'(hOutValid), 128'(1));
         checkOp("half.op0", 5, 10, 64'(op0), hSign[0], 64'(hExp[5:0]), 64'(hSig[10:0]),
                 hClass[4:0]);
         checkOp("half.op1", 5, 10, 64'(op1), hSign[1], 64'(hExp[11:6]), 64'(hSig[21:11]),
                 hClass[9:5]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
